// File: rtl/capture_mem_pkg.sv
// Shared definitions for the trigger-aware capture buffer: FSM encodings and default widths,
// also consumed by the bus register map.
package capture_mem_pkg;

  typedef logic [1:0] cm_state_t;

  localparam cm_state_t ST_IDLE  = 2'd0;
  localparam cm_state_t ST_ARMED = 2'd1;
  localparam cm_state_t ST_POST  = 2'd2;
  localparam cm_state_t ST_DONE  = 2'd3;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_DAT_WIDTH  = 32;

endpackage

// File: rtl/capture_mem_ram.sv
// Simple dual-port read-first RAM (port a writes, port b reads) for the capture buffer.
// Define CAPTURE_MEM_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module capture_mem_ram #(
  parameter  int addr_width = 11,
  parameter  int dat_width  = 32,
  localparam int mem_depth  = 1 << addr_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [addr_width-1:0] wr_adr_i,
  input  logic [dat_width-1:0]  wr_dat_i,
  input  logic                  rd_en_i,
  input  logic [addr_width-1:0] rd_adr_i,
  output logic [dat_width-1:0]  rd_dat_o,
  output logic                  rd_vld_o
);

  logic [dat_width-1:0] mem [mem_depth];
  logic [dat_width-1:0] rd_dat_q;
  logic                 rd_vld_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem[wr_adr_i] <= wr_dat_i;
  end

  // Non-blocking read of the array gives read-first behaviour on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en_i;
      if (rd_en_i) rd_dat_q <= mem[rd_adr_i];
    end
  end

`ifdef CAPTURE_MEM_OUTREG_EN
  logic [dat_width-1:0] out_dat_q;
  logic                 out_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_dat_q <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= rd_vld_q;
      if (rd_vld_q) out_dat_q <= rd_dat_q;
    end
  end

  assign rd_dat_o = out_dat_q;
  assign rd_vld_o = out_vld_q;
`else
  assign rd_dat_o = rd_dat_q;
  assign rd_vld_o = rd_vld_q;
`endif

endmodule

// File: rtl/capture_mem.sv
// Trigger-aware circular capture buffer: FSM, write pointer, post-trigger counter and status.
// Optional CAPTURE_MEM_OUTREG_EN adds a read output register inside capture_mem_ram.
module capture_mem
  import capture_mem_pkg::*;
#(
  parameter  int addr_width = DEF_ADDR_WIDTH,
  parameter  int dat_width  = DEF_DAT_WIDTH,
  localparam int mem_depth  = 1 << addr_width
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  smp_vld,
  input  logic [dat_width-1:0]  smp_dat_i,
  input  logic                  trig,
  input  logic [addr_width-1:0] post_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped,
  output logic [addr_width-1:0] trig_adr,
  output logic [addr_width-1:0] start_adr,
  input  logic                  rd_en,
  input  logic [addr_width-1:0] rd_adr,
  output logic [dat_width-1:0]  rd_dat_o,
  output logic                  rd_vld
);

  localparam logic [addr_width-1:0] LAST_ADR = addr_width'(mem_depth - 1);

  cm_state_t             state_q, state_d;
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic [addr_width-1:0] trig_adr_q, trig_adr_d;
  logic                  wrapped_q, wrapped_d;
  logic                  busy_q, done_q;
  logic                  wr_en;

  // post_cnt is addr_width bits, so it can never exceed depth-1 and the trigger sample survives.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    trig_adr_d = trig_adr_q;
    wrapped_d  = wrapped_q;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm) begin
          state_d   = ST_ARMED;
          wr_ptr_d  = '0;
          wrapped_d = 1'b0;
        end
      end
      ST_ARMED, ST_POST: begin
        if (smp_vld) begin
          wr_en    = ~rst;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_ADR) wrapped_d = 1'b1;
          if (state_q == ST_ARMED) begin
            if (trig) begin
              trig_adr_d = wr_ptr_q;
              cnt_d      = post_cnt;
              state_d    = (post_cnt == '0) ? ST_DONE : ST_POST;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == addr_width'(1)) state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      trig_adr_q <= '0;
      wrapped_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      trig_adr_q <= trig_adr_d;
      wrapped_q  <= wrapped_d;
      busy_q     <= (state_d == ST_ARMED) || (state_d == ST_POST);
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;
  assign trig_adr  = trig_adr_q;
  assign start_adr = wrapped_q ? wr_ptr_q : '0;

  capture_mem_ram #(
    .addr_width(addr_width),
    .dat_width (dat_width)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (wr_en),
    .wr_adr_i(wr_ptr_q),
    .wr_dat_i(smp_dat_i),
    .rd_en_i (rd_en),
    .rd_adr_i(rd_adr),
    .rd_dat_o(rd_dat_o),
    .rd_vld_o(rd_vld)
  );

endmodule
